// File: rtl/qsys_spi_csn_out_pkg.sv
// Shared register addresses, FSM state type and STATUS bit positions
// for the SPI chip-select output block.
package qsys_spi_csn_out_pkg;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_STATUS   = 2'd1;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
  localparam logic [1:0] ADDR_GUARD    = 2'd3;

  typedef enum logic {
    IDLE = 1'b0,
    GAP  = 1'b1
  } state_t;

  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_DONE_BIT = 1;

endpackage

// File: rtl/qsys_spi_csn_out_if.sv
// Avalon-MM slave bus bundle for the chip-select output block.
interface qsys_spi_csn_out_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );

endinterface

// File: rtl/qsys_csn_guard_timer.sv
// Guard-gap down-counter: load, decrement, zero flag. Saturates at zero.
module qsys_csn_guard_timer #(
  parameter int GUARD_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic [GUARD_W-1:0] load_val,
  input  logic               dec,
  output logic [GUARD_W-1:0] cnt,
  output logic               zero
);

  logic [GUARD_W-1:0] cnt_q;
  logic [GUARD_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - GUARD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/qsys_spi_csn_out.sv
// Active-low SPI chip-select driver with programmable all-deasserted
// guard gap between asserted patterns, sticky done flag and maskable irq.
module qsys_spi_csn_out
  import qsys_spi_csn_out_pkg::*;
#(
  parameter int                WIDTH       = 1,
  parameter int                GUARD_W     = 8,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  qsys_spi_csn_out_if.slave    bus,
  output logic [WIDTH-1:0]     out_port,
  output logic                 irq
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   out_port_q, out_port_d;
  logic [WIDTH-1:0]   pending_q, pending_d;
  logic               done_q, done_d;
  logic               irq_mask_q, irq_mask_d;
  logic [GUARD_W-1:0] guard_q, guard_d;
  logic [31:0]        readdata_q, readdata_d;

  logic               wr;
  logic               wr_data, wr_status, wr_mask, wr_guard;
  logic [WIDTH-1:0]   wdata_v;
  logic               done_set;
  logic               tmr_load, tmr_dec, tmr_zero;
  logic [GUARD_W-1:0] tmr_cnt;

  assign wr        = bus.chipselect & ~bus.write_n;
  assign wr_data   = wr && (bus.address == ADDR_DATA);
  assign wr_status = wr && (bus.address == ADDR_STATUS);
  assign wr_mask   = wr && (bus.address == ADDR_IRQ_MASK);
  assign wr_guard  = wr && (bus.address == ADDR_GUARD);
  assign wdata_v   = bus.writedata[WIDTH-1:0];

  qsys_csn_guard_timer #(
    .GUARD_W (GUARD_W)
  ) u_guard_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (guard_q - GUARD_W'(1)),
    .dec      (tmr_dec),
    .cnt      (tmr_cnt),
    .zero     (tmr_zero)
  );

  // Pending always tracks the latest DATA write; in GAP the value present
  // when the counter expires (including a write in that same cycle) wins.
  always_comb begin
    state_d    = state_q;
    out_port_d = out_port_q;
    pending_d  = pending_q;
    done_set   = 1'b0;
    tmr_load   = 1'b0;
    tmr_dec    = 1'b0;

    if (wr_data) begin
      pending_d = wdata_v;
    end

    case (state_q)
      IDLE: begin
        if (wr_data && (wdata_v != out_port_q)) begin
          if ((out_port_q == ALL_ONES) || (guard_q == '0)) begin
            out_port_d = wdata_v;
            done_set   = 1'b1;
          end else begin
            out_port_d = ALL_ONES;
            tmr_load   = 1'b1;
            state_d    = GAP;
          end
        end
      end
      GAP: begin
        if (tmr_zero) begin
          out_port_d = pending_d;
          done_set   = 1'b1;
          state_d    = IDLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A completion in the same cycle as a STATUS write keeps done set.
  always_comb begin
    done_d = done_q;
    if (wr_status) begin
      done_d = 1'b0;
    end
    if (done_set) begin
      done_d = 1'b1;
    end
  end

  always_comb begin
    irq_mask_d = irq_mask_q;
    guard_d    = guard_q;
    if (wr_mask) begin
      irq_mask_d = bus.writedata[0];
    end
    if (wr_guard) begin
      guard_d = bus.writedata[GUARD_W-1:0];
    end
  end

  always_comb begin
    readdata_d = '0;
    case (bus.address)
      ADDR_DATA:     readdata_d = 32'(out_port_q);
      ADDR_STATUS: begin
        readdata_d[STATUS_BUSY_BIT] = (state_q == GAP);
        readdata_d[STATUS_DONE_BIT] = done_q;
      end
      ADDR_IRQ_MASK: readdata_d[0] = irq_mask_q;
      ADDR_GUARD:    readdata_d    = 32'(guard_q);
      default:       readdata_d    = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      out_port_q <= RESET_VALUE;
      pending_q  <= ALL_ONES;
      done_q     <= 1'b0;
      irq_mask_q <= 1'b0;
      guard_q    <= '0;
      readdata_q <= '0;
    end else begin
      state_q    <= state_d;
      out_port_q <= out_port_d;
      pending_q  <= pending_d;
      done_q     <= done_d;
      irq_mask_q <= irq_mask_d;
      guard_q    <= guard_d;
      readdata_q <= readdata_d;
    end
  end

  assign out_port     = out_port_q;
  assign irq          = done_q & irq_mask_q;
  assign bus.readdata = readdata_q;

endmodule

// File: tb/tb_qsys_spi_csn_out.sv
// Scoreboard bench for qsys_spi_csn_out (WIDTH=2, GUARD_W=8): expected
// per-cycle out_port/readdata/irq are queued with stimulus and checked on negedges.
module tb_qsys_spi_csn_out;
  import qsys_spi_csn_out_pkg::*;

  typedef struct {
    logic [1:0]  outp;
    bit          chk;
    logic [31:0] rd;
    logic        irq;
  } exp_t;

  logic       clk;
  logic       reset_n;
  logic [1:0] out_port;
  logic       irq;
  int         tests_run;
  int         failures;
  exp_t       sb[$];

  qsys_spi_csn_out_if bus_if ();

  qsys_spi_csn_out #(
    .WIDTH   (2),
    .GUARD_W (8)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus_if),
    .out_port (out_port),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  function automatic void push(logic [1:0] o, bit c, logic [31:0] r, logic i);
    exp_t e;
    e.outp = o;
    e.chk  = c;
    e.rd   = r;
    e.irq  = i;
    sb.push_back(e);
  endfunction

  // Called at a negedge; returns at the negedge after the write edge.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus_if.address    = a;
    bus_if.writedata  = d;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    @(negedge clk);
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
  endtask

  task automatic test_reset();
    tests_run++;
    if (out_port !== 2'b11) begin
      failures++;
      $display("FAIL reset_out_port got %b want %b", out_port, 2'b11);
    end
    tests_run++;
    if (bus_if.readdata !== 32'd0) begin
      failures++;
      $display("FAIL reset_readdata got %0h want 0", bus_if.readdata);
    end
    tests_run++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL reset_irq got %b want 0", irq);
    end
    bus_if.address = ADDR_STATUS;
    @(negedge clk);
    tests_run++;
    if (bus_if.readdata !== 32'd0) begin
      failures++;
      $display("FAIL reset_status got %0h want 0", bus_if.readdata);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_direct();
    exp_t e;
    push(2'b00, 1, 32'd3, 1'b0);
    push(2'b00, 1, 32'd2, 1'b0);
    push(2'b00, 1, 32'd2, 1'b0);
    push(2'b00, 1, 32'd0, 1'b0);
    bus_write(ADDR_DATA, 32'h0);
    bus_if.address = ADDR_STATUS;
    for (int k = 0; sb.size() > 0; k++) begin
      if (k == 2) bus_write(ADDR_STATUS, 32'h0);
      else if (k > 0) @(negedge clk);
      e = sb.pop_front();
      tests_run++;
      if (out_port !== e.outp) begin
        failures++;
        $display("FAIL direct k=%0d out_port got %b want %b", k, out_port, e.outp);
      end
      if (e.chk) begin
        tests_run++;
        if (bus_if.readdata !== e.rd) begin
          failures++;
          $display("FAIL direct k=%0d readdata got %0h want %0h", k, bus_if.readdata, e.rd);
        end
      end
      tests_run++;
      if (irq !== e.irq) begin
        failures++;
        $display("FAIL direct k=%0d irq got %b want %b", k, irq, e.irq);
      end
    end
    $display("[TB] test_direct done");
  endtask

  task automatic test_gap();
    exp_t e;
    bus_write(ADDR_DATA, 32'h2);
    bus_write(ADDR_GUARD, 32'd3);
    bus_write(ADDR_STATUS, 32'h0);
    push(2'b11, 1, 32'd2, 1'b0);
    push(2'b11, 1, 32'd1, 1'b0);
    push(2'b11, 1, 32'd1, 1'b0);
    push(2'b01, 1, 32'd1, 1'b0);
    push(2'b01, 1, 32'd2, 1'b0);
    bus_write(ADDR_DATA, 32'h1);
    bus_if.address = ADDR_STATUS;
    for (int k = 0; sb.size() > 0; k++) begin
      if (k > 0) @(negedge clk);
      e = sb.pop_front();
      tests_run++;
      if (out_port !== e.outp) begin
        failures++;
        $display("FAIL gap k=%0d out_port got %b want %b", k, out_port, e.outp);
      end
      if (e.chk) begin
        tests_run++;
        if (bus_if.readdata !== e.rd) begin
          failures++;
          $display("FAIL gap k=%0d status got %0h want %0h", k, bus_if.readdata, e.rd);
        end
      end
      tests_run++;
      if (irq !== e.irq) begin
        failures++;
        $display("FAIL gap k=%0d irq got %b want %b", k, irq, e.irq);
      end
    end
    $display("[TB] test_gap done");
  endtask

  task automatic test_gap_rewrite();
    exp_t e;
    bus_write(ADDR_STATUS, 32'h0);
    push(2'b11, 1, 32'd1, 1'b0);
    push(2'b11, 1, 32'd3, 1'b0);
    push(2'b11, 1, 32'd3, 1'b0);
    push(2'b00, 1, 32'd3, 1'b0);
    push(2'b00, 1, 32'd0, 1'b0);
    bus_write(ADDR_DATA, 32'h2);
    for (int k = 0; sb.size() > 0; k++) begin
      if (k == 2) bus_write(ADDR_DATA, 32'h0);
      else if (k > 0) @(negedge clk);
      e = sb.pop_front();
      tests_run++;
      if (out_port !== e.outp) begin
        failures++;
        $display("FAIL rewrite k=%0d out_port got %b want %b", k, out_port, e.outp);
      end
      if (e.chk) begin
        tests_run++;
        if (bus_if.readdata !== e.rd) begin
          failures++;
          $display("FAIL rewrite k=%0d readdata got %0h want %0h", k, bus_if.readdata, e.rd);
        end
      end
    end
    $display("[TB] test_gap_rewrite done");
  endtask

  task automatic test_irq();
    exp_t e;
    bus_write(ADDR_STATUS, 32'h0);
    bus_write(ADDR_IRQ_MASK, 32'h1);
    push(2'b11, 1, 32'd0, 1'b0);
    push(2'b11, 1, 32'd1, 1'b0);
    push(2'b11, 1, 32'd1, 1'b0);
    push(2'b01, 1, 32'd1, 1'b1);
    push(2'b01, 1, 32'd2, 1'b1);
    bus_write(ADDR_DATA, 32'h1);
    bus_if.address = ADDR_STATUS;
    for (int k = 0; sb.size() > 0; k++) begin
      if (k > 0) @(negedge clk);
      e = sb.pop_front();
      tests_run++;
      if (irq !== e.irq) begin
        failures++;
        $display("FAIL irq_set k=%0d irq got %b want %b", k, irq, e.irq);
      end
      tests_run++;
      if (out_port !== e.outp || bus_if.readdata !== e.rd) begin
        failures++;
        $display("FAIL irq_set k=%0d out/rd got %b/%0h want %b/%0h",
                 k, out_port, bus_if.readdata, e.outp, e.rd);
      end
    end
    // STATUS write lands on the completion edge: done must stay set.
    bus_write(ADDR_STATUS, 32'h0);
    push(2'b11, 1, 32'd1, 1'b0);
    push(2'b11, 1, 32'd1, 1'b0);
    push(2'b11, 1, 32'd1, 1'b0);
    push(2'b10, 1, 32'd1, 1'b1);
    push(2'b10, 1, 32'd2, 1'b1);
    bus_write(ADDR_DATA, 32'h2);
    bus_if.address = ADDR_STATUS;
    for (int k = 0; sb.size() > 0; k++) begin
      if (k == 3) bus_write(ADDR_STATUS, 32'h0);
      else if (k > 0) @(negedge clk);
      e = sb.pop_front();
      tests_run++;
      if (irq !== e.irq) begin
        failures++;
        $display("FAIL irq_setwins k=%0d irq got %b want %b", k, irq, e.irq);
      end
      tests_run++;
      if (out_port !== e.outp || bus_if.readdata !== e.rd) begin
        failures++;
        $display("FAIL irq_setwins k=%0d out/rd got %b/%0h want %b/%0h",
                 k, out_port, bus_if.readdata, e.outp, e.rd);
      end
    end
    $display("[TB] test_irq done");
  endtask

  task automatic test_same_value();
    exp_t       e;
    logic [1:0] ra [4];
    ra = '{ADDR_GUARD, ADDR_IRQ_MASK, ADDR_DATA, ADDR_STATUS};
    bus_write(ADDR_STATUS, 32'h0);
    push(2'b10, 1, 32'd2, 1'b0);
    push(2'b10, 1, 32'd0, 1'b0);
    push(2'b10, 1, 32'd0, 1'b0);
    push(2'b10, 1, 32'd0, 1'b0);
    bus_write(ADDR_DATA, 32'h2);
    bus_if.address = ADDR_STATUS;
    for (int k = 0; sb.size() > 0; k++) begin
      if (k > 0) @(negedge clk);
      e = sb.pop_front();
      tests_run++;
      if (out_port !== e.outp || bus_if.readdata !== e.rd || irq !== e.irq) begin
        failures++;
        $display("FAIL same_value k=%0d out/rd/irq got %b/%0h/%b want %b/%0h/%b",
                 k, out_port, bus_if.readdata, irq, e.outp, e.rd, e.irq);
      end
    end
    push(2'b10, 1, 32'd3, 1'b0);
    push(2'b10, 1, 32'd1, 1'b0);
    push(2'b10, 1, 32'd2, 1'b0);
    push(2'b10, 1, 32'd0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      bus_if.address = ra[k];
      @(negedge clk);
      e = sb.pop_front();
      tests_run++;
      if (bus_if.readdata !== e.rd) begin
        failures++;
        $display("FAIL read addr=%0d readdata got %0h want %0h", ra[k], bus_if.readdata, e.rd);
      end
    end
    $display("[TB] test_same_value done");
  endtask

  task automatic test_guard_max();
    exp_t e;
    bus_write(ADDR_STATUS, 32'h0);
    bus_write(ADDR_GUARD, 32'd255);
    for (int k = 0; k < 257; k++) begin
      push((k < 255) ? 2'b11 : 2'b01, 0, 32'd0, (k < 255) ? 1'b0 : 1'b1);
    end
    bus_write(ADDR_DATA, 32'h1);
    for (int k = 0; sb.size() > 0; k++) begin
      if (k > 0) @(negedge clk);
      e = sb.pop_front();
      tests_run++;
      if (out_port !== e.outp || irq !== e.irq) begin
        failures++;
        $display("FAIL guard_max k=%0d out/irq got %b/%b want %b/%b",
                 k, out_port, irq, e.outp, e.irq);
      end
    end
    $display("[TB] test_guard_max done");
  endtask

  task automatic test_reset_mid_gap();
    bus_write(ADDR_DATA, 32'h2);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (out_port !== 2'b11 || bus_if.readdata !== 32'd0 || irq !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_gap out/rd/irq got %b/%0h/%b want 11/0/0",
               out_port, bus_if.readdata, irq);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    bus_if.address = ADDR_STATUS;
    @(negedge clk);
    tests_run++;
    if (bus_if.readdata !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid_gap status got %0h want 0", bus_if.readdata);
    end
    bus_if.address = ADDR_GUARD;
    @(negedge clk);
    tests_run++;
    if (bus_if.readdata !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid_gap guard got %0h want 0", bus_if.readdata);
    end
    repeat (300) @(negedge clk);
    tests_run++;
    if (out_port !== 2'b11) begin
      failures++;
      $display("FAIL reset_mid_gap deferred out_port got %b want 11", out_port);
    end
    $display("[TB] test_reset_mid_gap done");
  endtask

  initial begin
    clk               = 1'b0;
    reset_n           = 1'b0;
    tests_run         = 0;
    failures          = 0;
    bus_if.address    = ADDR_DATA;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.writedata  = 32'h0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    test_reset();
    test_direct();
    test_gap();
    test_gap_rewrite();
    test_irq();
    test_same_value();
    test_guard_max();
    test_reset_mid_gap();

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule

// File: doc/qsys_spi_csn_out.md
# qsys_spi_csn_out

Avalon-MM slave that drives the active-low SPI chip-select lines for the Bluetooth SPP master; it is the output-side companion of the chip-select input PIO. Software writes a requested chip-select pattern. The block enforces a programmable all-deasserted guard gap before switching from one asserted pattern to another, then reports completion through a sticky flag and a maskable interrupt. It sits in the Qsys system beside the SPI core and input PIO, on the same clk/reset_n domain.

## Interface
- `WIDTH`, 1, number of chip-select lines.
- `GUARD_W`, 8, width of guard-cycle register.
- `RESET_VALUE`, all ones, out_port value after reset (all lines deasserted).

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `address`  in  2  register select.
- `chipselect`  in  1  Avalon slave select.
- `write_n`  in  1  active-low write strobe.
- `writedata`  in  32  write data; upper unused bits ignored.
- `readdata`  out  32  registered read data; unused bits read 0.
- `out_port`  out  WIDTH  chip-select lines; 0 = asserted.
- `irq`  out  1  interrupt request = done & irq_mask.

## Operation
Register map:
- 0 DATA: write sets pending[WIDTH-1:0]; read returns current out_port.
- 1 STATUS: bit0 busy (state GAP), bit1 done (sticky); any write clears done.
- 2 IRQ_MASK: bit0 R/W.
- 3 GUARD: GUARD_W bits R/W; gap length in clk cycles.

A write is `chipselect & ~write_n`, sampled at the rising edge.

FSM states:
- **IDLE**: on a DATA write with value V:
  - V == out_port: no-op; done is not set.
  - out_port is all ones, or GUARD == 0: out_port <= V and done is set; stay IDLE.
  - Otherwise: out_port <= all ones, cnt <= GUARD-1, go to GAP.
- **GAP**: if cnt == 0, out_port <= pending, done is set, go to IDLE; else cnt decrements.
  - A DATA write during GAP updates pending only; cnt is not restarted, and the last written value is applied.
  - A GUARD write during GAP affects the next transition only.

Other rules:
- Done set and STATUS write in the same cycle: set wins.
- irq is combinational from the done and irq_mask registers, with no extra latency.

## Timing
- Reset values: out_port = RESET_VALUE, pending = all ones, readdata = 0, irq = 0, irq_mask = 0, GUARD = 0, done = 0, state IDLE, cnt = 0.
- Reset mid-GAP: immediate return to reset values; no deferred apply.
- Read latency: readdata is registered every clk from the current address. Data is valid the cycle after address is presented; chipselect is not required for the read mux.
- Direct-path DATA write at edge T: out_port = V from edge T; done is 1 and irq updates from edge T.
- Gap path, GUARD = N ≥ 1, write at edge T: out_port is all ones for exactly N cycles (edges T..T+N-1), V appears at edge T+N, and done is set at edge T+N. busy = 1 from T through T+N-1.
- GUARD = max (2^GUARD_W − 1) is legal; cnt holds GUARD_W bits and never wraps below 0.

## Structure
- Package `qsys_spi_csn_out_pkg` holds:
  - address constants ADDR_DATA = 0, ADDR_STATUS = 1, ADDR_IRQ_MASK = 2, ADDR_GUARD = 3;
  - the state typedef {IDLE, GAP};
  - STATUS bit indices.
- One sub-module `qsys_csn_guard_timer` (load / decrement / zero flag, GUARD_W wide) is natural. The top level holds the register file, FSM and read mux.

## Test plan
- Reset: hold reset_n low mid-operation → out_port = 1, readdata = 0, irq = 0, STATUS reads 0.
- WIDTH = 1, GUARD = 0: write DATA = 0 → out_port = 0 at the write edge, STATUS = 2. Write STATUS → STATUS = 0.
- WIDTH = 2, GUARD = 3, out_port = 2'b10: write DATA = 2'b01 → out_port = 2'b11 for exactly 3 cycles, then 2'b01. busy = 1 for 3 cycles, then done = 1.
- Same setup, second DATA write of 2'b00 in gap cycle 2 → gap still ends after 3 cycles and out_port = 2'b00.
- IRQ_MASK = 1: transition completes → irq = 1. Write STATUS in the same cycle as the next completion → done stays 1, irq stays 1.
- Same-value DATA write while IDLE → out_port unchanged, done unchanged, busy never asserts. Read each address → value appears one cycle later.
